// File: rtl/sipo.sv
// MSB-first serial-to-parallel deserializer with a valid/ready holding
// register, sticky overrun flag and synchronous word realign.
module sipo #(
    parameter int WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sin,
    input  logic                     sin_en,
    input  logic                     sync,
    output logic [WIDTH-1:0]         pout,
    output logic                     pout_valid,
    input  logic                     pout_ready,
    output logic                     overrun,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Only the first WIDTH-1 bits of a word need storage; the last bit
    // arrives on sin and goes straight into the holding register.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] word;
    logic             complete;
    logic             take;

    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        pout_d   = pout_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        word     = {shreg_q, sin};
        complete = sin_en && !sync && (cnt_q == LAST);
        take     = valid_q && pout_ready;

        if (sync) begin
            shreg_d = '0;
            cnt_d   = '0;
            if (sin_en) begin
                shreg_d[0] = sin;
                cnt_d      = CW'(1);
            end
        end else if (sin_en) begin
            shreg_d = word[WIDTH-2:0];
            cnt_d   = complete ? '0 : cnt_q + CW'(1);
        end

        if (complete && (!valid_q || take)) begin
            pout_d  = word;
            valid_d = 1'b1;
        end else if (complete) begin
            ovr_d = 1'b1;
        end else if (take) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign pout       = pout_q;
    assign pout_valid = valid_q;
    assign overrun    = ovr_q;
    assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sipo.sv
// Scoreboard bench for sipo (WIDTH=4): expected words are queued as
// stimulus is driven and popped whenever the DUT presents a new word.
module tb_sipo;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         sin;
    logic         sin_en;
    logic         sync;
    logic [W-1:0] pout;
    logic         pout_valid;
    logic         pout_ready;
    logic         overrun;
    logic [1:0]   bit_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] sb_q[$];
    logic         prev_valid;
    logic         prev_ready;

    sipo #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .sin        (sin),
        .sin_en     (sin_en),
        .sync       (sync),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .overrun    (overrun),
        .bit_cnt    (bit_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A new word is on pout when valid is high and the previous cycle
    // either held nothing or handed its word over.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (pout_valid && (!prev_valid || prev_ready)) begin
                if (sb_q.size() == 0) begin
                    chk("sb_extra", 32'(pout), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_word", 32'(pout), 32'(sb_q.pop_front()));
                end
            end
            prev_valid = pout_valid;
            prev_ready = pout_ready;
        end
    end

    task automatic step(input logic b, input logic en, input logic s);
        sin    = b;
        sin_en = en;
        sync   = s;
        @(posedge clock);
        #1;
        sin_en = 1'b0;
        sync   = 1'b0;
        sin    = 1'b0;
    endtask

    task automatic bit_in(input logic b);
        step(b, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        sin        = 1'b0;
        sin_en     = 1'b0;
        sync       = 1'b0;
        pout_ready = 1'b0;
        #1;
        chk("rst0_pout", 32'(pout), 0);
        chk("rst0_valid", 32'(pout_valid), 0);
        chk("rst0_ovr", 32'(overrun), 0);
        chk("rst0_cnt", 32'(bit_cnt), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic word
        pout_ready = 1'b1;
        sb_q.push_back(4'b1010);
        bit_in(1'b1); chk("basic_cnt1", 32'(bit_cnt), 1);
        bit_in(1'b0); chk("basic_cnt2", 32'(bit_cnt), 2);
        bit_in(1'b1); chk("basic_cnt3", 32'(bit_cnt), 3);
        chk("basic_nv", 32'(pout_valid), 0);
        bit_in(1'b0); chk("basic_cnt0", 32'(bit_cnt), 0);
        chk("basic_pout", 32'(pout), 32'hA);
        chk("basic_valid", 32'(pout_valid), 1);
        idle(1);
        chk("basic_1cyc", 32'(pout_valid), 0);
        chk("basic_hold", 32'(pout), 32'hA);

        // Gapped input
        sb_q.push_back(4'b1101);
        bit_in(1'b1); idle(2); chk("gap_nv1", 32'(pout_valid), 0);
        bit_in(1'b1); idle(2); chk("gap_nv2", 32'(pout_valid), 0);
        chk("gap_cnt", 32'(bit_cnt), 2);
        bit_in(1'b0); idle(2); chk("gap_nv3", 32'(pout_valid), 0);
        bit_in(1'b1);
        chk("gap_pout", 32'(pout), 32'hD);
        chk("gap_valid", 32'(pout_valid), 1);
        idle(1);

        // Back-pressure and overrun
        pout_ready = 1'b0;
        sb_q.push_back(4'b1010);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
        chk("bp_valid1", 32'(pout_valid), 1);
        chk("bp_ovr0", 32'(overrun), 0);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
        chk("bp_pout", 32'(pout), 32'hA);
        chk("bp_valid2", 32'(pout_valid), 1);
        chk("bp_ovr1", 32'(overrun), 1);
        pout_ready = 1'b1;
        idle(1);
        chk("bp_drain", 32'(pout_valid), 0);
        chk("bp_sticky", 32'(overrun), 1);

        // Same-edge consume and load
        pulse_reset();
        chk("se_ovr_clr", 32'(overrun), 0);
        pout_ready = 1'b0;
        sb_q.push_back(4'b1010);
        sb_q.push_back(4'b0011);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
        bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
        chk("se_held", 32'(pout), 32'hA);
        pout_ready = 1'b1;
        bit_in(1'b1);
        chk("se_pout", 32'(pout), 32'h3);
        chk("se_valid", 32'(pout_valid), 1);
        chk("se_ovr", 32'(overrun), 0);
        idle(1);
        chk("se_drain", 32'(pout_valid), 0);

        // Realign
        sb_q.push_back(4'b1001);
        bit_in(1'b1); bit_in(1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("sync_cnt", 32'(bit_cnt), 1);
        bit_in(1'b0); bit_in(1'b0);
        chk("sync_nv", 32'(pout_valid), 0);
        bit_in(1'b1);
        chk("sync_pout", 32'(pout), 32'h9);
        chk("sync_valid", 32'(pout_valid), 1);
        idle(1);

        // Sync on the edge that would complete a word, under back-pressure
        pout_ready = 1'b0;
        sb_q.push_back(4'b0110);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("syncc_cnt", 32'(bit_cnt), 1);
        chk("syncc_nv", 32'(pout_valid), 0);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
        chk("syncc_pout", 32'(pout), 32'h6);
        sb_q.push_back(4'b1111);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("syncd_ovr", 32'(overrun), 0);
        chk("syncd_pout", 32'(pout), 32'h6);
        pout_ready = 1'b1;
        idle(1);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
        chk("syncd_word", 32'(pout), 32'hF);
        idle(1);

        // Asynchronous reset mid-cycle
        pout_ready = 1'b0;
        sb_q.push_back(4'b1100);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b0);
        bit_in(1'b1); bit_in(1'b0);
        chk("ar_pre_cnt", 32'(bit_cnt), 2);
        chk("ar_pre_valid", 32'(pout_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_pout", 32'(pout), 0);
        chk("ar_valid", 32'(pout_valid), 0);
        chk("ar_ovr", 32'(overrun), 0);
        chk("ar_cnt", 32'(bit_cnt), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(2);

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
